// File: rtl/ex_mem_wb_forward_stage_if.sv
// Bus between the execute stage and the EX/MEM-MEM/WB forwarding block.
// The master drives the execute-side signals and the slave returns registers, selects and stall.
interface ex_mem_wb_forward_stage_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
);
  logic               enable_i;
  logic               flush_i;
  logic [NB_DATA-1:0] alu_result_i;
  logic [NB_DATA-1:0] data_rb_i;
  logic [NB_REG-1:0]  writeReg_i;
  logic               regWrite_i;
  logic               memRead_i;
  logic               memWrite_i;
  logic               memToReg_i;
  logic [NB_REG-1:0]  id_ex_rs_i;
  logic [NB_REG-1:0]  id_ex_rt_i;
  logic [NB_DATA-1:0] mem_read_data_i;

  logic [NB_DATA-1:0] ex_mem_alu_result_o;
  logic [NB_DATA-1:0] ex_mem_data_rb_o;
  logic               ex_mem_memRead_o;
  logic               ex_mem_memWrite_o;
  logic [NB_REG-1:0]  wb_writeReg_o;
  logic               wb_regWrite_o;
  logic [NB_DATA-1:0] ex_mem_data_o;
  logic [NB_DATA-1:0] mem_wb_data_o;
  logic [1:0]         forward_signal_regA_o;
  logic [1:0]         forward_signal_regB_o;
  logic               ex_stall_o;

  modport master (
    output enable_i, flush_i, alu_result_i, data_rb_i, writeReg_i, regWrite_i, memRead_i,
           memWrite_i, memToReg_i, id_ex_rs_i, id_ex_rt_i, mem_read_data_i,
    input  ex_mem_alu_result_o, ex_mem_data_rb_o, ex_mem_memRead_o, ex_mem_memWrite_o,
           wb_writeReg_o, wb_regWrite_o, ex_mem_data_o, mem_wb_data_o,
           forward_signal_regA_o, forward_signal_regB_o, ex_stall_o
  );

  modport slave (
    input  enable_i, flush_i, alu_result_i, data_rb_i, writeReg_i, regWrite_i, memRead_i,
           memWrite_i, memToReg_i, id_ex_rs_i, id_ex_rt_i, mem_read_data_i,
    output ex_mem_alu_result_o, ex_mem_data_rb_o, ex_mem_memRead_o, ex_mem_memWrite_o,
           wb_writeReg_o, wb_regWrite_o, ex_mem_data_o, mem_wb_data_o,
           forward_signal_regA_o, forward_signal_regB_o, ex_stall_o
  );
endinterface

// File: rtl/ex_mem_wb_forward_stage.sv
// EX/MEM and MEM/WB pipeline registers with operand forwarding selects and load-use stall.
module ex_mem_wb_forward_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
) (
  input logic                     clock_i,
  input logic                     reset_n_i,
  ex_mem_wb_forward_stage_if.slave bus
);

  logic [NB_DATA-1:0] ex_alu_q, ex_rb_q;
  logic [NB_REG-1:0]  ex_wreg_q;
  logic               ex_regwrite_q, ex_memread_q, ex_memwrite_q, ex_memtoreg_q;

  logic [NB_DATA-1:0] wb_alu_q, wb_rd_q;
  logic [NB_REG-1:0]  wb_wreg_q;
  logic               wb_regwrite_q, wb_memtoreg_q;

  logic haz_a, haz_b, stall, bubble;

  // A load in EX/MEM cannot be forwarded until its data reaches MEM/WB.
  assign haz_a  = ex_memread_q & ex_regwrite_q & (ex_wreg_q != '0) &
                  (ex_wreg_q == bus.id_ex_rs_i);
  assign haz_b  = ex_memread_q & ex_regwrite_q & (ex_wreg_q != '0) &
                  (ex_wreg_q == bus.id_ex_rt_i);
  assign stall  = haz_a | haz_b;
  assign bubble = bus.flush_i | stall;

  function automatic logic [1:0] fwd_sel(input logic [NB_REG-1:0] src, input logic haz);
    if (ex_regwrite_q && !ex_memread_q && ex_wreg_q != '0 && ex_wreg_q == src) begin
      return 2'b01;
    end else if (!haz && wb_regwrite_q && wb_wreg_q != '0 && wb_wreg_q == src) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_alu_q      <= '0;
      ex_rb_q       <= '0;
      ex_wreg_q     <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_memtoreg_q <= 1'b0;
      wb_alu_q      <= '0;
      wb_rd_q       <= '0;
      wb_wreg_q     <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
    end else if (bus.enable_i) begin
      if (bubble) begin
        ex_alu_q      <= '0;
        ex_rb_q       <= '0;
        ex_wreg_q     <= '0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
        ex_memwrite_q <= 1'b0;
        ex_memtoreg_q <= 1'b0;
      end else begin
        ex_alu_q      <= bus.alu_result_i;
        ex_rb_q       <= bus.data_rb_i;
        ex_wreg_q     <= bus.writeReg_i;
        ex_regwrite_q <= bus.regWrite_i;
        ex_memread_q  <= bus.memRead_i;
        ex_memwrite_q <= bus.memWrite_i;
        ex_memtoreg_q <= bus.memToReg_i;
      end
      // MEM/WB keeps advancing under stall so the load completes.
      wb_alu_q      <= ex_alu_q;
      wb_rd_q       <= bus.mem_read_data_i;
      wb_wreg_q     <= ex_wreg_q;
      wb_regwrite_q <= ex_regwrite_q;
      wb_memtoreg_q <= ex_memtoreg_q;
    end
  end

  assign bus.ex_mem_alu_result_o   = ex_alu_q;
  assign bus.ex_mem_data_rb_o      = ex_rb_q;
  assign bus.ex_mem_memRead_o      = ex_memread_q;
  assign bus.ex_mem_memWrite_o     = ex_memwrite_q;
  assign bus.wb_writeReg_o         = wb_wreg_q;
  assign bus.wb_regWrite_o         = wb_regwrite_q;
  assign bus.ex_mem_data_o         = ex_alu_q;
  assign bus.mem_wb_data_o         = wb_memtoreg_q ? wb_rd_q : wb_alu_q;
  assign bus.forward_signal_regA_o = fwd_sel(bus.id_ex_rs_i, haz_a);
  assign bus.forward_signal_regB_o = fwd_sel(bus.id_ex_rt_i, haz_b);
  assign bus.ex_stall_o            = stall;

endmodule

// File: tb/tb_ex_mem_wb_forward_stage.sv
// Scoreboard bench for ex_mem_wb_forward_stage: expectations queued with stimulus, popped on compare.
module tb_ex_mem_wb_forward_stage;

  localparam int SigFwdA = 0, SigFwdB = 1, SigStall = 2, SigExAlu = 3, SigExRb = 4,
                 SigExRd = 5, SigExWr = 6, SigWbReg = 7, SigWbRegWr = 8, SigExData = 9,
                 SigWbData = 10;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  ex_mem_wb_forward_stage_if #(.NB_DATA(32), .NB_REG(5)) bus_if ();

  ex_mem_wb_forward_stage #(.NB_DATA(32), .NB_REG(5)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      SigFwdA:    return {30'b0, bus_if.forward_signal_regA_o};
      SigFwdB:    return {30'b0, bus_if.forward_signal_regB_o};
      SigStall:   return {31'b0, bus_if.ex_stall_o};
      SigExAlu:   return bus_if.ex_mem_alu_result_o;
      SigExRb:    return bus_if.ex_mem_data_rb_o;
      SigExRd:    return {31'b0, bus_if.ex_mem_memRead_o};
      SigExWr:    return {31'b0, bus_if.ex_mem_memWrite_o};
      SigWbReg:   return {27'b0, bus_if.wb_writeReg_o};
      SigWbRegWr: return {31'b0, bus_if.wb_regWrite_o};
      SigExData:  return bus_if.ex_mem_data_o;
      SigWbData:  return bus_if.mem_wb_data_o;
      default:    return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic compare_all();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, actual(e.sig), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] alu, input logic [31:0] rb, input logic [4:0] wreg,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic [4:0] rs, input logic [4:0] rt);
    bus_if.alu_result_i = alu;
    bus_if.data_rb_i    = rb;
    bus_if.writeReg_i   = wreg;
    bus_if.regWrite_i   = rw;
    bus_if.memRead_i    = mr;
    bus_if.memWrite_i   = mw;
    bus_if.memToReg_i   = m2r;
    bus_if.id_ex_rs_i   = rs;
    bus_if.id_ex_rt_i   = rt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.enable_i        = 1'b1;
    bus_if.flush_i         = 1'b0;
    bus_if.mem_read_data_i = '0;
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    #12 rst_n = 1'b1;
    tick();

    // Reset: build nonzero state, then assert reset between edges.
    drive_ex(32'h1234, 32'h5678, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 5'd0);
    bus_if.mem_read_data_i = 32'hCAFE;
    tick();
    expect_val("pre_reset_stall", SigStall, 32'd1);
    expect_val("pre_reset_alu", SigExAlu, 32'h1234);
    compare_all();
    #2 rst_n = 1'b0;
    expect_val("rst_ex_alu", SigExAlu, 32'h0);
    expect_val("rst_ex_rb", SigExRb, 32'h0);
    expect_val("rst_ex_rd", SigExRd, 32'h0);
    expect_val("rst_stall", SigStall, 32'h0);
    expect_val("rst_fwd_a", SigFwdA, 32'h0);
    expect_val("rst_wb_regwr", SigWbRegWr, 32'h0);
    expect_val("rst_wb_data", SigWbData, 32'h0);
    compare_all();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    bus_if.mem_read_data_i = '0;
    #1 rst_n = 1'b1;
    tick();

    // ALU chain r5 = 0xAA: EX/MEM forward, then MEM/WB forward.
    drive_ex(32'hAA, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    drive_ex(32'h33, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
    expect_val("chain_fwd_a", SigFwdA, 32'h1);
    expect_val("chain_fwd_b0", SigFwdB, 32'h0);
    expect_val("chain_ex_data", SigExData, 32'hAA);
    compare_all();
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5);
    expect_val("chain_fwd_b", SigFwdB, 32'h2);
    expect_val("chain_fwd_a0", SigFwdA, 32'h0);
    expect_val("chain_wb_data", SigWbData, 32'hAA);
    compare_all();
    tick();

    // Priority: both stages hold r7, newer value wins.
    drive_ex(32'h11, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    drive_ex(32'h22, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7);
    expect_val("prio_fwd_a", SigFwdA, 32'h1);
    expect_val("prio_fwd_b", SigFwdB, 32'h1);
    expect_val("prio_ex_data", SigExData, 32'h22);
    expect_val("prio_wb_data", SigWbData, 32'h11);
    compare_all();
    tick();

    // Load-use on r3 via rt.
    drive_ex(32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
    tick();
    drive_ex(32'h55, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3);
    bus_if.mem_read_data_i = 32'hDEAD_BEEF;
    expect_val("lu_stall", SigStall, 32'h1);
    expect_val("lu_fwd_b_hold", SigFwdB, 32'h0);
    expect_val("lu_ex_rd", SigExRd, 32'h1);
    compare_all();
    tick();
    bus_if.mem_read_data_i = 32'h0;
    expect_val("lu_stall_clr", SigStall, 32'h0);
    expect_val("lu_bubble_rd", SigExRd, 32'h0);
    expect_val("lu_bubble_alu", SigExAlu, 32'h0);
    expect_val("lu_fwd_b", SigFwdB, 32'h2);
    expect_val("lu_wb_data", SigWbData, 32'hDEAD_BEEF);
    expect_val("lu_wb_reg", SigWbReg, 32'd3);
    compare_all();
    tick();

    // r0 is never forwarded and never stalls.
    drive_ex(32'h77, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_val("r0_fwd_a", SigFwdA, 32'h0);
    expect_val("r0_fwd_b", SigFwdB, 32'h0);
    expect_val("r0_stall", SigStall, 32'h0);
    compare_all();
    tick();

    // Enable low freezes everything, even with flush and new inputs.
    drive_ex(32'h50, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    drive_ex(32'h40, 32'hBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    bus_if.enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_ex($urandom, $urandom, 5'(i + 10), 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd0);
      bus_if.mem_read_data_i = $urandom;
      bus_if.flush_i = (i == 1);
      tick();
      expect_val("frz_ex_alu", SigExAlu, 32'h40);
      expect_val("frz_ex_rb", SigExRb, 32'hBEEF);
      expect_val("frz_ex_wr", SigExWr, 32'h1);
      expect_val("frz_wb_reg", SigWbReg, 32'd4);
      expect_val("frz_wb_data", SigWbData, 32'h50);
      compare_all();
    end
    bus_if.enable_i = 1'b1;
    bus_if.flush_i  = 1'b1;
    drive_ex(32'h99, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    bus_if.flush_i = 1'b0;
    expect_val("flush_ex_wr", SigExWr, 32'h0);
    expect_val("flush_ex_alu", SigExAlu, 32'h0);
    expect_val("flush_wb_data", SigWbData, 32'h40);
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
